// File: rtl/mu0_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mu0_pkg : opcodes, ALU function codes and FSM states for the MU0 controller
// Rev 1.0
// ---------------------------------------------------------------------------
package mu0_pkg;

  localparam int INSTR_COUNT_W = 16;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  // LDA, STA, ADD and SUB are the only opcodes that touch memory in EXEC
  function automatic logic is_mem_op(input logic [3:0] f);
    return f <= OP_SUB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mu0_control_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mu0_control_if : control bundle between MU0 controller and datapath/memory
// Rev 1.0
// ---------------------------------------------------------------------------
interface mu0_control_if;
  import mu0_pkg::*;

  logic [3:0]               F;
  logic                     N;
  logic                     Z;
  logic                     Mem_ack;
  logic                     Addr_sel;
  logic                     X_sel;
  logic                     Y_sel;
  logic [1:0]               ALU_fs;
  logic                     Acc_En;
  logic                     PC_En;
  logic                     IR_En;
  logic                     Mem_rd;
  logic                     Mem_wr;
  logic                     Halted;
  logic                     Fault;
  logic [INSTR_COUNT_W-1:0] Instr_count;

  modport master (
    input  F, N, Z, Mem_ack,
    output Addr_sel, X_sel, Y_sel, ALU_fs, Acc_En, PC_En, IR_En,
           Mem_rd, Mem_wr, Halted, Fault, Instr_count
  );

  modport slave (
    output F, N, Z, Mem_ack,
    input  Addr_sel, X_sel, Y_sel, ALU_fs, Acc_En, PC_En, IR_En,
           Mem_rd, Mem_wr, Halted, Fault, Instr_count
  );

endinterface
`default_nettype wire

// File: rtl/mu0_ack_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mu0_ack_timer : memory wait counter with timeout compare (TIMEOUT=0 disables)
// Rev 1.0
// ---------------------------------------------------------------------------
module mu0_ack_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic nReset,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int            W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt;

  // Clearing on ack means the next access (FETCH or memory EXEC) starts at zero
  always_ff @(posedge clk) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (active) begin
      if (ack)
        cnt <= '0;
      else if (cnt != LIMIT)
        cnt <= cnt + W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && active && !ack && (cnt == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mu0_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mu0_control : fetch/execute sequencer driving the 12-bit MU0 datapath
// Rev 1.0
// ---------------------------------------------------------------------------
module mu0_control
  import mu0_pkg::*;
#(
  parameter int                       TIMEOUT    = 15,
  parameter logic [INSTR_COUNT_W-1:0] COUNT_INIT = '0
) (
  input  logic          Clk,
  input  logic          nReset,
  mu0_control_if.master bus
);

  state_t                   state;
  logic                     run;
  logic [INSTR_COUNT_W-1:0] count;
  logic                     live;
  logic                     mem_op;
  logic                     access;
  logic                     expired;
  logic                     retire;

  // run holds everything idle for the cycle in which nReset is first seen high
  assign live   = run & nReset;
  assign mem_op = is_mem_op(bus.F);
  assign access = live && ((state == FETCH) || (state == EXEC && mem_op));

  mu0_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (Clk),
    .nReset  (nReset),
    .active  (access),
    .ack     (bus.Mem_ack),
    .expired (expired)
  );

  always_comb begin
    retire = 1'b0;
    if (live && state == EXEC && !bus.F[3])
      retire = mem_op ? bus.Mem_ack : 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      run   <= 1'b0;
      state <= FETCH;
      count <= COUNT_INIT;
    end else begin
      run <= 1'b1;
      if (run) begin
        unique case (state)
          FETCH: begin
            if (bus.Mem_ack)
              state <= EXEC;
            else if (expired)
              state <= FAULT;
          end
          EXEC: begin
            if (bus.F[3])
              state <= FAULT;
            else if (bus.F == OP_STP)
              state <= HALT;
            else if (!mem_op || bus.Mem_ack)
              state <= FETCH;
            else if (expired)
              state <= FAULT;
          end
          HALT:  state <= HALT;
          FAULT: state <= FAULT;
        endcase
        if (retire)
          count <= count + INSTR_COUNT_W'(1);
      end
    end
  end

  always_comb begin
    bus.Addr_sel    = 1'b0;
    bus.X_sel       = 1'b0;
    bus.Y_sel       = 1'b0;
    bus.ALU_fs      = ALU_Y;
    bus.Acc_En      = 1'b0;
    bus.PC_En       = 1'b0;
    bus.IR_En       = 1'b0;
    bus.Mem_rd      = 1'b0;
    bus.Mem_wr      = 1'b0;
    bus.Halted      = 1'b0;
    bus.Fault       = 1'b0;
    bus.Instr_count = live ? count : '0;
    if (live) begin
      unique case (state)
        FETCH: begin
          bus.Mem_rd = 1'b1;
          bus.X_sel  = 1'b1;
          bus.ALU_fs = ALU_INC;
          bus.IR_En  = bus.Mem_ack;
          bus.PC_En  = bus.Mem_ack;
        end
        EXEC: begin
          case (bus.F)
            OP_LDA, OP_ADD, OP_SUB: begin
              bus.Mem_rd   = 1'b1;
              bus.Addr_sel = 1'b1;
              bus.Acc_En   = bus.Mem_ack;
              bus.ALU_fs   = (bus.F == OP_ADD) ? ALU_ADD :
                             (bus.F == OP_SUB) ? ALU_SUB : ALU_Y;
            end
            OP_STA: begin
              bus.Mem_wr   = 1'b1;
              bus.Addr_sel = 1'b1;
            end
            OP_JMP: begin
              bus.Y_sel = 1'b1;
              bus.PC_En = 1'b1;
            end
            OP_JGE: begin
              bus.Y_sel = 1'b1;
              bus.PC_En = ~bus.N;
            end
            OP_JNE: begin
              bus.Y_sel = 1'b1;
              bus.PC_En = ~bus.Z;
            end
            default: ;
          endcase
        end
        HALT:  bus.Halted = 1'b1;
        FAULT: bus.Fault  = 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mu0_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mu0_control : random stimulus against a cycle-level behavioural model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mu0_control;

  localparam int TO    = 3;
  localparam int NCYC  = 6000;
  localparam int WINIT = 16'hFFFE;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] f    = '0;
  logic       n    = 1'b0;
  logic       z    = 1'b0;
  logic       ack  = 1'b0;

  mu0_control_if bus ();
  mu0_control_if bus2 ();

  assign bus.F        = f;
  assign bus.N        = n;
  assign bus.Z        = z;
  assign bus.Mem_ack  = ack;
  assign bus2.F       = f;
  assign bus2.N       = n;
  assign bus2.Z       = z;
  assign bus2.Mem_ack = ack;

  mu0_control #(.TIMEOUT(TO)) dut (
    .Clk    (clk),
    .nReset (nrst),
    .bus    (bus)
  );

  mu0_control #(.TIMEOUT(TO), .COUNT_INIT(16'hFFFE)) dut_wrap (
    .Clk    (clk),
    .nReset (nrst),
    .bus    (bus2)
  );

  always #5 clk = ~clk;

  logic [11:0] ctl1, ctl2;
  assign ctl1 = {bus.Addr_sel, bus.X_sel, bus.Y_sel, bus.ALU_fs, bus.Acc_En,
                 bus.PC_En, bus.IR_En, bus.Mem_rd, bus.Mem_wr, bus.Halted, bus.Fault};
  assign ctl2 = {bus2.Addr_sel, bus2.X_sel, bus2.Y_sel, bus2.ALU_fs, bus2.Acc_En,
                 bus2.PC_En, bus2.IR_En, bus2.Mem_rd, bus2.Mem_wr, bus2.Halted, bus2.Fault};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // Model: 0=fetch 1=exec 2=halt 3=fault; waited = cycles spent without ack
  int mode, waited, retired, rate;
  bit run;

  initial begin
    logic a_s, x_s, y_s, acc, pce, ire, rd, wr, hl, ft;
    logic ca, cx, cy, cf;
    logic [1:0]  fs;
    logic [11:0] e, c;
    logic [15:0] ecnt, ecnt2;
    int fi;

    mode = 0; waited = 0; retired = 0; run = 0; rate = 100;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 0;
          1: rate = 40;
          2: rate = 80;
          default: rate = 100;
        endcase
      end
      if (cyc < 2)        nrst = 1'b0;
      else if (mode >= 2) nrst = ($urandom_range(0, 4) != 0);
      else                nrst = ($urandom_range(0, 199) != 0);
      // IR is stable throughout an execute phase
      if (mode != 1)
        f = ($urandom_range(0, 9) != 0) ? 4'($urandom_range(0, 7)) : 4'($urandom_range(8, 15));
      n   = 1'($urandom_range(0, 1));
      z   = 1'($urandom_range(0, 1));
      ack = ($urandom_range(0, 99) < rate);
      #2;

      fi = int'(f);
      {a_s, x_s, y_s, acc, pce, ire, rd, wr, hl, ft} = '0;
      fs = 2'b00;
      {ca, cx, cy, cf} = 4'hF;
      ecnt  = 16'(retired);
      ecnt2 = 16'((retired + WINIT) % 65536);
      if (!nrst || !run) begin
        ecnt = '0; ecnt2 = '0;
      end else begin
        case (mode)
          0: begin
            x_s = 1; fs = 2'b10; rd = 1; ire = ack; pce = ack; cy = 0;
          end
          1: begin
            if (fi <= 3) begin
              a_s = 1;
              if (fi == 1) begin
                wr = 1; cx = 0; cy = 0; cf = 0;
              end else begin
                rd = 1; acc = ack;
                fs = (fi == 2) ? 2'b01 : (fi == 3) ? 2'b11 : 2'b00;
                if (fi == 0) cx = 0;
              end
            end else if (fi <= 6) begin
              y_s = 1; ca = 0; cx = 0;
              pce = (fi == 4) ? 1'b1 : (fi == 5) ? !n : !z;
            end else begin
              ca = 0; cx = 0; cy = 0; cf = 0;
            end
          end
          2: begin hl = 1; ca = 0; cx = 0; cy = 0; cf = 0; end
          default: begin ft = 1; ca = 0; cx = 0; cy = 0; cf = 0; end
        endcase
      end
      e = {a_s, x_s, y_s, fs, acc, pce, ire, rd, wr, hl, ft};
      c = {ca, cx, cy, cf, cf, 7'h7F};
      chk("ctl", 16'(ctl1 & c), 16'(e & c));
      chk("count", bus.Instr_count, ecnt);
      chk("ctl_wrap", 16'(ctl2 & c), 16'(e & c));
      chk("count_wrap", bus2.Instr_count, ecnt2);

      // State advance at the coming rising edge
      if (!nrst) begin
        mode = 0; waited = 0; retired = 0; run = 0;
      end else if (!run) begin
        run = 1;
      end else begin
        case (mode)
          0: begin
            if (ack) begin mode = 1; waited = 0; end
            else if (waited == TO) mode = 3;
            else waited++;
          end
          1: begin
            if (fi >= 8) mode = 3;
            else if (fi == 7) begin mode = 2; retired = (retired + 1) % 65536; end
            else if (fi >= 4) begin mode = 0; retired = (retired + 1) % 65536; end
            else if (ack) begin mode = 0; waited = 0; retired = (retired + 1) % 65536; end
            else if (waited == TO) mode = 3;
            else waited++;
          end
          default: ;
        endcase
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
